// File: rtl/shift_rows_pipe.sv
// Purpose: pipelined Rijndael ShiftRows / InvShiftRows stage for 128/192/256-bit states, per-beat direction select, sideband tag.
// Latency: STAGES cycles; the permutation sits ahead of stage 0 and later stages are plain registers.
// Backpressure: valid/ready with bubble collapse. in_ready follows out_ready combinationally through the stage chain.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous drop of every in-flight beat (the data registers keep their contents)
//   in_valid/in_ready input handshake; in_inv selects the inverse permutation; in_tag and in_data form the beat
//   out_valid/out_ready output handshake; out_tag and out_data come from the last stage
module shift_rows_pipe #(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [32*NB-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [32*NB-1:0]  out_data
);

  localparam int DW = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("shift_rows_pipe: STAGES must be in 1..4");
  end

  // Row shift offsets. The 256-bit state uses wider offsets for rows 2 and 3.
  function automatic int row_shift(input int r);
    if (r == 0)             return 0;
    if (NB == 8 && r >= 2)  return r + 1;
    return r;
  endfunction

  logic [DW-1:0]     w_fwd;
  logic [DW-1:0]     w_inv;
  logic [DW-1:0]     w_perm;
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_src_vld;
  logic [TAG_W-1:0]  w_src_tag [STAGES];
  logic [DW-1:0]     w_src_dat [STAGES];

  logic [STAGES-1:0] r_vld;
  logic [TAG_W-1:0]  r_tag [STAGES];
  logic [DW-1:0]     r_dat [STAGES];

  // Pure wiring. Byte (r,c) sits at [32*(NB-1-c)+8*(3-r) +: 8], so byte (0,0) is at the MSB end.
  for (genvar gr = 0; gr < 4; gr++) begin : g_row
    for (genvar gc = 0; gc < NB; gc++) begin : g_col
      localparam int S  = row_shift(gr);
      localparam int CF = (gc + S) % NB;
      localparam int CI = (gc - S + NB) % NB;
      assign w_fwd[32*(NB-1-gc)+8*(3-gr) +: 8] = in_data[32*(NB-1-CF)+8*(3-gr) +: 8];
      assign w_inv[32*(NB-1-gc)+8*(3-gr) +: 8] = in_data[32*(NB-1-CI)+8*(3-gr) +: 8];
    end
  end

  assign w_perm = in_inv ? w_inv : w_fwd;

  // Each stage's load source: stage 0 takes the permuted input and stage k takes stage k-1.
  always_comb begin
    w_src_vld    = '0;
    w_src_vld[0] = in_valid;
    w_src_tag[0] = in_tag;
    w_src_dat[0] = w_perm;
    for (int k = 1; k < STAGES; k++) begin
      w_src_vld[k] = r_vld[k-1];
      w_src_tag[k] = r_tag[k-1];
      w_src_dat[k] = r_dat[k-1];
    end
  end

  // A stage loads when it is empty or is being drained. It is drained when the next stage
  // loads, or by out_ready at the tail. The chain is resolved from the tail back to stage 0,
  // which lets empty slots (bubbles) fill even while the output is stalled.
  always_comb begin : p_chain
    logic w_dn;
    w_load = '0;
    w_dn   = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_dn      = !r_vld[k] || w_dn;
      w_load[k] = w_dn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_tag[k] <= '0;
        r_dat[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_vld[k] <= w_src_vld[k];
          r_tag[k] <= w_src_tag[k];
          r_dat[k] <= w_src_dat[k];
        end
      end
      // flush only kills the valid bits; the data payload is left as it is.
      if (flush) r_vld <= '0;
    end
  end

  assign in_ready  = rst_n && !flush && w_load[0];
  assign out_valid = r_vld[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];
  assign out_data  = r_dat[STAGES-1];

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: three instances (NB=4/STAGES=1, NB=8/STAGES=2, NB=4/STAGES=3)
// checked against a byte-array ShiftRows reference model.
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance a: NB=4, STAGES=1
  logic a_flush, a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready;
  logic [3:0] a_in_tag, a_out_tag;
  logic [127:0] a_in_data, a_out_data;
  // Instance b: NB=8, STAGES=2
  logic b_flush, b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready;
  logic [3:0] b_in_tag, b_out_tag;
  logic [255:0] b_in_data, b_out_data;
  // Instance c: NB=4, STAGES=3
  logic c_flush, c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready;
  logic [3:0] c_in_tag, c_out_tag;
  logic [127:0] c_in_data, c_out_data;

  shift_rows_pipe #(.NB(4), .STAGES(1), .TAG_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_inv(a_in_inv), .in_tag(a_in_tag), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_tag(a_out_tag), .out_data(a_out_data));

  shift_rows_pipe #(.NB(8), .STAGES(2), .TAG_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_inv(b_in_inv), .in_tag(b_in_tag), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_tag(b_out_tag), .out_data(b_out_data));

  shift_rows_pipe #(.NB(4), .STAGES(3), .TAG_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_inv(c_in_inv), .in_tag(c_in_tag), .in_data(c_in_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_tag(c_out_tag), .out_data(c_out_data));

  // Reference: state bytes in stream order (index 4*c+r, MSB first), rotated per row.
  function automatic logic [255:0] ref_shift(input int nb, input logic [255:0] din, input bit inv);
    logic [7:0] b [32];
    logic [7:0] o [32];
    logic [255:0] res;
    int s;
    int src;
    for (int i = 0; i < 4*nb; i++) b[i] = din[8*(4*nb-1-i) +: 8];
    for (int c = 0; c < nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        s = (r == 0) ? 0 : ((nb == 8 && r > 1) ? r + 1 : r);
        src = inv ? (c - s + nb) % nb : (c + s) % nb;
        o[4*c+r] = b[4*src+r];
      end
    end
    res = '0;
    for (int i = 0; i < 4*nb; i++) res[8*(4*nb-1-i) +: 8] = o[i];
    return res;
  endfunction

  function automatic logic [127:0] ref4(input logic [127:0] d, input bit inv);
    logic [255:0] t;
    t = ref_shift(4, {128'd0, d}, inv);
    return t[127:0];
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_a_vld got %b want 0", a_out_valid); end
    n_cmp++; if (a_out_data !== 128'd0) begin n_bad++; $display("FAIL rst_a_data got %h want 0", a_out_data); end
    n_cmp++; if (a_out_tag !== 4'd0) begin n_bad++; $display("FAIL rst_a_tag got %h want 0", a_out_tag); end
    n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_a_rdy got %b want 0", a_in_ready); end
    n_cmp++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_b got vld=%b rdy=%b want 0/0", b_out_valid, b_in_ready); end
    n_cmp++; if (c_out_valid !== 1'b0 || c_in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_c got vld=%b rdy=%b want 0/0", c_out_valid, c_in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_fips;
    logic [127:0] exp_d;
    logic [3:0] exp_t;
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_inv = 1'b0; a_in_tag = 4'd3;
    a_in_data = 128'hd42711aee0bf98f1b8b45de51e415230;
    #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL fips_rdy got %b want 1", a_in_ready); end
    step;
    a_in_inv = 1'b1; a_in_tag = 4'd5;
    a_in_data = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    #1;
    n_cmp++; if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL fips_fwd_vld got %b want 1", a_out_valid); end
    n_cmp++; if (a_out_data !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin n_bad++; $display("FAIL fips_fwd_data got %h want d4bf5d30e0b452aeb84111f11e2798e5", a_out_data); end
    n_cmp++; if (a_out_tag !== 4'd3) begin n_bad++; $display("FAIL fips_fwd_tag got %h want 3", a_out_tag); end
    step;
    a_in_valid = 1'b0;
    #1;
    n_cmp++; if (a_out_data !== 128'hd42711aee0bf98f1b8b45de51e415230 || a_out_valid !== 1'b1) begin n_bad++; $display("FAIL fips_inv_data got %h vld=%b want d42711aee0bf98f1b8b45de51e415230 vld=1", a_out_data, a_out_valid); end
    n_cmp++; if (a_out_tag !== 4'd5) begin n_bad++; $display("FAIL fips_inv_tag got %h want 5", a_out_tag); end
    step;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL fips_idle_vld got %b want 0", a_out_valid); end
    // Back-to-back alternating direction: one result per cycle, no bubbles.
    exp_d = '0; exp_t = '0;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        a_in_valid = 1'b1; a_in_inv = i[0]; a_in_tag = i[3:0];
        a_in_data = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        a_in_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== exp_d || a_out_tag !== exp_t) begin n_bad++; $display("FAIL b2b_%0d got vld=%b %h/%h want 1 %h/%h", i, a_out_valid, a_out_tag, a_out_data, exp_t, exp_d); end
      end
      if (i < 10) begin exp_d = ref4(a_in_data, a_in_inv); exp_t = i[3:0]; end
      step;
    end
  endtask

  task automatic test_nb8;
    logic [255:0] d;
    logic [255:0] fwd;
    for (int i = 0; i < 32; i++) d[8*(31-i) +: 8] = i[7:0];
    fwd = ref_shift(8, d, 1'b0);
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_inv = 1'b0; b_in_tag = 4'd9; b_in_data = d;
    #1;
    n_cmp++; if (b_in_ready !== 1'b1) begin n_bad++; $display("FAIL nb8_rdy got %b want 1", b_in_ready); end
    step;
    b_in_valid = 1'b0;
    #1;
    n_cmp++; if (b_out_valid !== 1'b0) begin n_bad++; $display("FAIL nb8_early got vld=%b want 0", b_out_valid); end
    step;
    // Feed the model's forward result straight back in the inverse direction.
    b_in_valid = 1'b1; b_in_inv = 1'b1; b_in_tag = 4'd2; b_in_data = fwd;
    #1;
    n_cmp++; if (b_out_valid !== 1'b1 || b_out_tag !== 4'd9) begin n_bad++; $display("FAIL nb8_fwd_vld got vld=%b tag=%h want 1 9", b_out_valid, b_out_tag); end
    n_cmp++; if (b_out_data[255:192] !== 64'h00050e1304091217) begin n_bad++; $display("FAIL nb8_fwd_head got %h want 00050e1304091217", b_out_data[255:192]); end
    n_cmp++; if (b_out_data !== fwd) begin n_bad++; $display("FAIL nb8_fwd_data got %h want %h", b_out_data, fwd); end
    step;
    b_in_valid = 1'b0;
    step;
    n_cmp++; if (b_out_valid !== 1'b1 || b_out_data !== d || b_out_tag !== 4'd2) begin n_bad++; $display("FAIL nb8_inv got vld=%b %h want 1 %h", b_out_valid, b_out_data, d); end
    step;
  endtask

  task automatic test_backpressure;
    logic [127:0] q_d[$];
    logic [3:0] q_t[$];
    logic [127:0] prev_d, ed;
    logic [3:0] prev_t, et;
    bit prev_stall, saw_full;
    int acc, emit, i;
    acc = 0; emit = 0; i = 0; prev_stall = 0; saw_full = 0; prev_d = '0; prev_t = '0;
    while (emit < 8 && i < 60) begin
      c_out_ready = !(i >= 4 && i <= 9);
      c_in_valid = (acc < 8); c_in_tag = acc[3:0]; c_in_inv = $urandom_range(0, 1);
      c_in_data = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (prev_stall) begin
        n_cmp++; if (c_out_valid !== 1'b1 || {c_out_tag, c_out_data} !== {prev_t, prev_d}) begin n_bad++; $display("FAIL bp_stable cyc %0d got %h/%h want %h/%h", i, c_out_tag, c_out_data, prev_t, prev_d); end
      end
      if (!c_in_ready) begin
        saw_full = 1;
        n_cmp++; if (acc - emit != 3) begin n_bad++; $display("FAIL bp_full_depth got %0d held want 3", acc - emit); end
      end
      if (c_in_valid && c_in_ready) begin q_d.push_back(ref4(c_in_data, c_in_inv)); q_t.push_back(c_in_tag); acc++; end
      if (c_out_valid && c_out_ready) begin
        ed = '0; et = '0;
        if (q_d.size() > 0) begin ed = q_d.pop_front(); et = q_t.pop_front(); end
        n_cmp++; if (c_out_data !== ed || c_out_tag !== et) begin n_bad++; $display("FAIL bp_order got %h/%h want %h/%h", c_out_tag, c_out_data, et, ed); end
        emit++;
      end
      prev_stall = c_out_valid && !c_out_ready; prev_d = c_out_data; prev_t = c_out_tag;
      i++;
      step;
    end
    c_in_valid = 1'b0; c_out_ready = 1'b1;
    n_cmp++; if (emit != 8 || q_d.size() != 0) begin n_bad++; $display("FAIL bp_count got %0d emitted %0d pending want 8 0", emit, q_d.size()); end
    n_cmp++; if (!saw_full) begin n_bad++; $display("FAIL bp_ready_drop got never want in_ready=0 during stall"); end
  endtask

  task automatic test_random;
    logic [127:0] q_d[$];
    logic [3:0] q_t[$];
    logic [127:0] prev_d, ed;
    logic [3:0] prev_t, et;
    bit prev_stall;
    int acc;
    acc = 0; prev_stall = 0; prev_d = '0; prev_t = '0;
    for (int i = 0; i < 400; i++) begin
      c_in_valid = (i < 300) && ($urandom_range(0, 9) < 7);
      c_out_ready = (i >= 300) || ($urandom_range(0, 9) < 6);
      c_in_tag = acc[3:0]; c_in_inv = $urandom_range(0, 1);
      c_in_data = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (prev_stall) begin
        n_cmp++; if (c_out_valid !== 1'b1 || {c_out_tag, c_out_data} !== {prev_t, prev_d}) begin n_bad++; $display("FAIL rnd_stable cyc %0d got %h/%h want %h/%h", i, c_out_tag, c_out_data, prev_t, prev_d); end
      end
      if (c_in_valid && c_in_ready) begin q_d.push_back(ref4(c_in_data, c_in_inv)); q_t.push_back(c_in_tag); acc++; end
      if (c_out_valid && c_out_ready) begin
        ed = '0; et = '0;
        if (q_d.size() > 0) begin ed = q_d.pop_front(); et = q_t.pop_front(); end
        n_cmp++; if (c_out_data !== ed || c_out_tag !== et) begin n_bad++; $display("FAIL rnd_data cyc %0d got %h/%h want %h/%h", i, c_out_tag, c_out_data, et, ed); end
      end
      prev_stall = c_out_valid && !c_out_ready; prev_d = c_out_data; prev_t = c_out_tag;
      step;
    end
    c_in_valid = 1'b0; c_out_ready = 1'b1;
    n_cmp++; if (q_d.size() != 0 || c_out_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_drain got %0d pending vld=%b want 0 0", q_d.size(), c_out_valid); end
  endtask

  task automatic test_flush;
    int seen;
    c_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      c_in_valid = 1'b1; c_in_inv = 1'b0; c_in_tag = 4'hE;
      c_in_data = {$urandom, $urandom, $urandom, $urandom};
      step;
    end
    c_in_tag = 4'hE; c_flush = 1'b1;
    #1;
    n_cmp++; if (c_in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_rdy got %b want 0", c_in_ready); end
    step;
    c_flush = 1'b0; c_in_valid = 1'b0;
    #1;
    n_cmp++; if (c_out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_next got vld=%b want 0", c_out_valid); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin step; if (c_out_valid === 1'b1) seen++; end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL flush_leak got %0d beats want 0", seen); end
  endtask

  task automatic test_reset_mid;
    logic [127:0] exp_d;
    c_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c_in_valid = 1'b1; c_in_inv = 1'b1; c_in_tag = i[3:0] + 4'd1;
      c_in_data = {$urandom, $urandom, $urandom, $urandom};
      step;
    end
    #1;
    n_cmp++; if (c_in_ready !== 1'b0 || c_out_valid !== 1'b1) begin n_bad++; $display("FAIL rstm_full got rdy=%b vld=%b want 0 1", c_in_ready, c_out_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (c_out_valid !== 1'b0 || c_out_data !== 128'd0 || c_out_tag !== 4'd0) begin n_bad++; $display("FAIL rstm_clear got vld=%b %h/%h want 0 0/0", c_out_valid, c_out_tag, c_out_data); end
    n_cmp++; if (c_in_ready !== 1'b0) begin n_bad++; $display("FAIL rstm_rdy got %b want 0", c_in_ready); end
    c_in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step;
    c_out_ready = 1'b1; c_in_valid = 1'b1; c_in_inv = 1'b0; c_in_tag = 4'hA;
    c_in_data = {$urandom, $urandom, $urandom, $urandom};
    exp_d = ref4(c_in_data, 1'b0);
    step;
    c_in_valid = 1'b0;
    #1;
    n_cmp++; if (c_out_valid !== 1'b0) begin n_bad++; $display("FAIL rstm_lat1 got vld=%b want 0", c_out_valid); end
    step;
    n_cmp++; if (c_out_valid !== 1'b0) begin n_bad++; $display("FAIL rstm_lat2 got vld=%b want 0", c_out_valid); end
    step;
    n_cmp++; if (c_out_valid !== 1'b1 || c_out_data !== exp_d || c_out_tag !== 4'hA) begin n_bad++; $display("FAIL rstm_lat3 got vld=%b %h/%h want 1 a/%h", c_out_valid, c_out_tag, c_out_data, exp_d); end
    step;
  endtask

  initial begin
    a_flush = 0; a_in_valid = 0; a_in_inv = 0; a_in_tag = 0; a_in_data = 0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_inv = 0; b_in_tag = 0; b_in_data = 0; b_out_ready = 0;
    c_flush = 0; c_in_valid = 0; c_in_inv = 0; c_in_tag = 0; c_in_data = 0; c_out_ready = 0;
    test_reset;
    test_fips;
    test_nb8;
    test_backpressure;
    test_random;
    test_flush;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
